oled_spi_fifo: RTL and testbench
================================

Name: oled_spi_fifo

Overview:
- AHB-lite slave that serialises display command/data frames onto the 4-wire OLED serial interface (nCS, DnC, SDIN, SCLK).
- Successor to the single-register display manager. Adds:
  - a parametrised transmit FIFO of tagged frames;
  - a programmable SCLK divider;
  - a per-frame 8/16-bit length and a per-frame DnC tag;
  - overflow reporting and a FIFO-level interrupt.
- Sits on the AHB bus beside the other peripherals. Software pushes frames without polling per frame.

Parameters:
- FIFO_DEPTH, 8, number of frame entries; power of 2, minimum 2.
- DIV_W, 8, width of the CLKDIV register.
- DEFAULT_DIV, 0, reset value of CLKDIV.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the FIFO level count (derived, not overridden).

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready.
- HWRITE  in  1  write/read.
- HADDR  in  32  address; only [3:2] decoded.
- HWDATA  in  32  write data.
- HSIZE  in  3  ignored; word access only.
- HTRANS  in  2  transfer type.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  always 1.
- IRQ  out  1  FIFO-level interrupt, active high.
- nCS  out  1  chip select, active low.
- DnC  out  1  1=data, 0=command.
- SDIN  out  1  serial data, MSB first.
- SCLK  out  1  serial clock, idle low.

Behaviour:
- Reset: HRESETn is the asynchronous, active-low reset; HCLK is the clock. All state clears asynchronously on HRESETn low.
  - Outputs after reset: nCS=1, SCLK=0, SDIN=0, DnC=0, IRQ=0.
  - FIFO empty, overflow=0, CTRL=0x00000001 (enable=1), CLKDIV=DEFAULT_DIV.
  - A frame in progress when reset asserts is abandoned immediately.
- AHB timing:
  - Address phase is registered when HSEL && HREADY && HTRANS!=IDLE.
  - The write takes effect at the end of the data phase, using HWDATA.
  - HRDATA is driven combinationally in the data phase from the registered address.
  - No wait states. Unmapped addresses read 0.
- Register map (HADDR[3:2]):
  - 0 DATA, write only; reads 0. Pushes one FIFO entry {len=HWDATA[17], dnc=HWDATA[16], data=HWDATA[15:0]}. len=0 sends data[7:0]; len=1 sends data[15:0].
  - 1 STATUS. Bit [0] busy (FSM not IDLE), [1] empty, [2] full, [3] overflow (sticky; write 1 clears), [16+LVL_W-1:16] level.
  - 2 CTRL. Bit [0] enable, [1] flush (write 1 empties the FIFO; self-clearing, reads 0), [2] irq_en, [15:8] thresh.
  - 3 CLKDIV. Bits [DIV_W-1:0]. Half-period H = CLKDIV+1 HCLK cycles.
- FIFO rules:
  - A push when full (full sampled before this cycle's pop) is dropped and sets overflow.
  - Push and pop in the same cycle leave the level unchanged.
  - Flush does not abort the frame already popped into the shifter.
- Serialiser FSM, states IDLE, LOW, HIGH, GAP:
  - IDLE: if enable && !empty, pop the head entry, latch data/len/dnc and H, go to LOW with bitcnt = len?15:7.
  - LOW (H cycles): nCS=0, SCLK=0, DnC=latched dnc, SDIN = current bit. Then go to HIGH.
  - HIGH (H cycles): SCLK=1, SDIN stable. At the end, if bitcnt==0 go to GAP; else decrement and go to LOW.
  - GAP (H cycles): nCS=1, SCLK=0, SDIN=0. Then go to IDLE.
  - DnC holds its last latched value while idle.
- Frame timing:
  - A frame of N bits occupies 1 + 2·N·H + H cycles from the pop cycle to the next possible pop.
  - nCS is low for exactly 2·N·H cycles.
  - SDIN changes only while SCLK is low.
- Mid-frame changes:
  - A CLKDIV write takes effect from the next frame.
  - Clearing enable lets the current frame complete; no further pops occur.
- IRQ = irq_en && (level <= thresh), registered (one-cycle lag after a level change).

Test Plan:
- Reset, then read STATUS -> 0x00000002; nCS=1, SCLK=0, SDIN=0, DnC=0, IRQ=0; CLKDIV reads DEFAULT_DIV.
- CLKDIV=0, write DATA=0x000000A5 -> nCS low exactly 16 cycles; SDIN at the 8 SCLK rises = 1,0,1,0,0,1,0,1; DnC=0; busy clears 18 cycles after the pop.
- CLKDIV=3, write DATA=0x00031234 -> DnC=1; each SCLK phase 4 cycles; 16 rises carry 0x1234 MSB first; nCS low 128 cycles; GAP 4 cycles.
- enable=0, write DATA FIFO_DEPTH+1 times (8-bit frames) -> STATUS full=1, overflow=1, level=8. Write STATUS 0x8 -> overflow=0. Set enable=1 -> exactly 8 frames sent, then empty=1.
- thresh=2, irq_en=1, enable=0, push 4 frames -> IRQ=0. Set enable=1 -> IRQ rises the cycle after the level reaches 2.
- Assert HRESETn mid-bit in a 16-bit frame -> outputs return to reset values immediately; FIFO empty; no further SCLK edges after release.

Source files
------------

// File: rtl/oled_spi_fifo.sv
// oled_spi_fifo
//   AHB-lite slave that queues tagged display frames and sends them on the
//   4-wire OLED serial interface. Each FIFO entry carries 8 or 16 data bits
//   plus a DnC tag. The SCLK half-period is programmable, and an interrupt
//   fires when the FIFO level is at or below a programmable threshold.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL .. HTRANS       AHB-lite slave inputs (only HADDR[3:2] decoded)
//   HRDATA, HREADYOUT    AHB-lite slave outputs (never inserts wait states)
//   IRQ                  FIFO-level interrupt, active high
//   nCS, DnC, SDIN, SCLK serial display interface (SCLK idles low, MSB first)
//
// Register map (HADDR[3:2])
//   0 DATA   W  {len[17], dnc[16], data[15:0]} pushes one frame
//   1 STATUS R  busy[0] empty[1] full[2] overflow[3] (W1C) level[16+:LVL_W]
//   2 CTRL   RW enable[0] flush[1] (self-clearing) irq_en[2] thresh[15:8]
//   3 CLKDIV RW SCLK half-period = CLKDIV+1 HCLK cycles
module oled_spi_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 0,
    parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        IRQ,
    output logic        nCS,
    output logic        DnC,
    output logic        SDIN,
    output logic        SCLK
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    // ---------------- AHB address phase capture ----------------
    logic       wr_q, rd_q;
    logic [1:0] addr_q;
    logic       ahb_go;

    assign ahb_go    = HSEL && HREADY && (HTRANS != 2'b00);
    assign HREADYOUT = 1'b1;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= 2'd0;
        end else if (HREADY) begin
            wr_q <= ahb_go && HWRITE;
            rd_q <= ahb_go && !HWRITE;
            if (ahb_go) addr_q <= HADDR[3:2];
        end
    end

    logic wr_data, wr_stat, wr_ctrl, wr_div;
    assign wr_data = wr_q && (addr_q == 2'd0);
    assign wr_stat = wr_q && (addr_q == 2'd1);
    assign wr_ctrl = wr_q && (addr_q == 2'd2);
    assign wr_div  = wr_q && (addr_q == 2'd3);

    // ---------------- Control registers ----------------
    logic             enable, irq_en, overflow;
    logic [7:0]       thresh;
    logic [DIV_W-1:0] clkdiv;

    // ---------------- Transmit FIFO ----------------
    logic [17:0]      mem [FIFO_DEPTH];
    logic [LVL_W-1:0] wr_ptr, rd_ptr, level;
    logic             full, empty, push_ok, pop, flush;
    logic [17:0]      head;
    state_t           state_q, state_d;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign push_ok = wr_data && !full;
    assign flush   = wr_ctrl && HWDATA[1];
    assign pop     = (state_q == S_IDLE) && enable && !empty;
    assign head    = mem[rd_ptr[LVL_W-2:0]];

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the contents would buy nothing.
    always_ff @(posedge HCLK) begin
        if (push_ok) mem[wr_ptr[LVL_W-2:0]] <= HWDATA[17:0];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            enable   <= 1'b1;
            irq_en   <= 1'b0;
            thresh   <= 8'd0;
            clkdiv   <= DIV_W'(DEFAULT_DIV);
            overflow <= 1'b0;
            IRQ      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + LVL_W'(1);
            // A flush discards what is queued; an entry popped this same
            // cycle is already latched into the shifter and still goes out.
            if (flush)    rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + LVL_W'(1);
            if (wr_ctrl) begin
                enable <= HWDATA[0];
                irq_en <= HWDATA[2];
                thresh <= HWDATA[15:8];
            end
            if (wr_div) clkdiv <= HWDATA[DIV_W-1:0];
            if (wr_data && full)             overflow <= 1'b1;
            else if (wr_stat && HWDATA[3])   overflow <= 1'b0;
            IRQ <= irq_en && (32'(level) <= 32'(thresh));
        end
    end

    // ---------------- Serialiser ----------------
    logic [DIV_W-1:0] hdiv, cnt;
    logic [15:0]      shreg;
    logic [3:0]       bitcnt;
    logic             dnc_q, tick;

    assign tick = (cnt == hdiv);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop)  state_d = S_LOW;
            S_LOW:   if (tick) state_d = S_HIGH;
            S_HIGH:  if (tick) state_d = (bitcnt == 4'd0) ? S_GAP : S_LOW;
            S_GAP:   if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt    <= '0;
            hdiv   <= '0;
            shreg  <= 16'd0;
            bitcnt <= 4'd0;
            dnc_q  <= 1'b0;
        end else begin
            // The phase counter runs only while a frame is in flight.
            if (state_q == S_IDLE || tick) cnt <= '0;
            else                           cnt <= cnt + DIV_W'(1);
            if (pop) begin
                shreg  <= head[15:0];
                dnc_q  <= head[16];
                bitcnt <= head[17] ? 4'd15 : 4'd7;
                hdiv   <= clkdiv;  // CLKDIV writes apply from the next frame
            end else if (state_q == S_HIGH && tick && bitcnt != 4'd0) begin
                bitcnt <= bitcnt - 4'd1;
            end
        end
    end

    assign nCS  = !(state_q == S_LOW || state_q == S_HIGH);
    assign SCLK = (state_q == S_HIGH);
    assign SDIN = !nCS && shreg[bitcnt];
    assign DnC  = dnc_q;

    // ---------------- Read mux ----------------
    always_comb begin
        HRDATA = 32'd0;
        if (rd_q) begin
            case (addr_q)
                2'd1: begin
                    HRDATA[0]          = (state_q != S_IDLE);
                    HRDATA[1]          = empty;
                    HRDATA[2]          = full;
                    HRDATA[3]          = overflow;
                    HRDATA[16 +: LVL_W] = level;
                end
                2'd2: begin
                    HRDATA[0]    = enable;
                    HRDATA[2]    = irq_en;
                    HRDATA[15:8] = thresh;
                end
                2'd3:    HRDATA[DIV_W-1:0] = clkdiv;
                default: HRDATA = 32'd0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:18]};

endmodule

// File: tb/tb_oled_spi_fifo.sv
// Self-checking bench for oled_spi_fifo. Frames pushed through the DATA
// register are recorded in a scoreboard queue; a serial monitor reassembles
// each frame from SCLK rising edges and compares it against the queue head,
// along with chip-select width, SCLK phase widths and frame spacing.
module tb_oled_spi_fifo;

    localparam int DEPTH = 8;
    localparam int DEFAULT_DIV = 0;

    typedef struct packed {
        logic        len;
        logic        dnc;
        logic [15:0] data;
    } frame_t;

    logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADYOUT, IRQ, nCS, DnC, SDIN, SCLK;

    frame_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    oled_spi_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(8), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .IRQ(IRQ),
        .nCS(nCS), .DnC(DnC), .SDIN(SDIN), .SCLK(SCLK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    task automatic ahb_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic expect_reg(input string name, input logic [1:0] a, input logic [31:0] want);
        logic [31:0] got;
        ahb_read(a, got);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    task automatic expect_pin(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic push_frame(input logic len, input logic dnc, input logic [15:0] data, input bit track);
        frame_t f;
        f.len = len; f.dnc = dnc; f.data = data;
        ahb_write(2'd0, {14'd0, len, dnc, data});
        if (track) exp_q.push_back(f);
    endtask

    // Monitor n back-to-back frames at half-period h; compare each against
    // the scoreboard head.
    task automatic run_frames(input int n, input int h, input int budget);
        int done = 0, cyc = 0, nbits = 0, ncs_low = 0, run = 0;
        int pmin = 1 << 30, pmax = 0, last_fall = -1, last_nbits = 0;
        int want_bits, want_period;
        logic [15:0] bits = 16'd0, want_data;
        logic prev_ncs = 1'b1, prev_sclk = 1'b0, prev_sdin = 1'b0;
        logic dnc_at = 1'b0, dnc_bad = 1'b0, sdin_bad = 1'b0;
        frame_t f;
        while (done < n && cyc < budget) begin
            @(posedge HCLK); #1;
            cyc++;
            if (!nCS) begin
                if (prev_ncs) begin
                    if (last_fall >= 0) begin
                        want_period = 1 + 2 * last_nbits * h + h;
                        vectors++;
                        if (cyc - last_fall !== want_period) begin
                            miscompares++;
                            $display("FAIL frame_period: got %0d want %0d", cyc - last_fall, want_period);
                        end
                    end
                    last_fall = cyc; nbits = 0; ncs_low = 0; bits = 16'd0;
                    pmin = 1 << 30; pmax = 0; dnc_bad = 1'b0; sdin_bad = 1'b0; dnc_at = DnC;
                    run = 1;
                end else if (SCLK != prev_sclk) begin
                    if (run < pmin) pmin = run;
                    if (run > pmax) pmax = run;
                    run = 1;
                end else begin
                    run++;
                end
                ncs_low++;
                if (SCLK && !prev_sclk) begin
                    bits = {bits[14:0], SDIN};
                    nbits++;
                    if (DnC !== dnc_at) dnc_bad = 1'b1;
                end
                if (SCLK && !prev_ncs && SDIN !== prev_sdin) sdin_bad = 1'b1;
            end else if (!prev_ncs) begin
                if (run < pmin) pmin = run;
                if (run > pmax) pmax = run;
                done++;
                last_nbits = nbits;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frame: got 0x%04h with nothing queued", bits);
                end else begin
                    f = exp_q.pop_front();
                    want_bits = f.len ? 16 : 8;
                    want_data = f.len ? f.data : {8'h00, f.data[7:0]};
                    if (nbits !== want_bits || bits !== want_data || dnc_at !== f.dnc) begin
                        miscompares++;
                        $display("FAIL frame_content: got %0d bits 0x%04h dnc %b want %0d bits 0x%04h dnc %b",
                                 nbits, bits, dnc_at, want_bits, want_data, f.dnc);
                    end
                    vectors++;
                    if (ncs_low !== 2 * want_bits * h) begin
                        miscompares++;
                        $display("FAIL ncs_low_width: got %0d want %0d", ncs_low, 2 * want_bits * h);
                    end
                    vectors++;
                    if (pmin !== h || pmax !== h) begin
                        miscompares++;
                        $display("FAIL sclk_phase: got min %0d max %0d want %0d", pmin, pmax, h);
                    end
                    vectors++;
                    if (dnc_bad !== 1'b0 || sdin_bad !== 1'b0) begin
                        miscompares++;
                        $display("FAIL pin_stability: got dnc_moved %b sdin_moved_high %b want 0 0", dnc_bad, sdin_bad);
                    end
                end
            end
            prev_ncs = nCS; prev_sclk = SCLK; prev_sdin = SDIN;
        end
        vectors++;
        if (done < n) begin
            miscompares++;
            $display("FAIL frame_timeout: got %0d frames want %0d", done, n);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;
        expect_pin("reset_ncs", nCS, 1'b1);
        expect_pin("reset_sclk", SCLK, 1'b0);
        expect_pin("reset_sdin", SDIN, 1'b0);
        expect_pin("reset_dnc", DnC, 1'b0);
        expect_pin("reset_irq", IRQ, 1'b0);
        expect_pin("reset_hreadyout", HREADYOUT, 1'b1);
        expect_reg("reset_status", 2'd1, 32'h0000_0002);
        expect_reg("reset_ctrl", 2'd2, 32'h0000_0001);
        expect_reg("reset_clkdiv", 2'd3, 32'(DEFAULT_DIV));
        expect_reg("data_reads_zero", 2'd0, 32'h0);
    endtask

    task automatic test_div0();
        ahb_write(2'd3, 32'd0);
        ahb_write(2'd2, 32'h0);
        push_frame(1'b0, 1'b0, 16'h00A5, 1'b1);
        push_frame(1'b0, 1'b1, 16'h005A, 1'b1);
        ahb_write(2'd2, 32'h1);
        run_frames(2, 1, 200);
        repeat (4) @(posedge HCLK); #1;
        expect_pin("dnc_holds_idle", DnC, 1'b1);
        expect_reg("div0_status_idle", 2'd1, 32'h0000_0002);
    endtask

    task automatic test_div3();
        ahb_write(2'd3, 32'd3);
        expect_reg("clkdiv_readback", 2'd3, 32'd3);
        ahb_write(2'd2, 32'h0);
        push_frame(1'b1, 1'b1, 16'h1234, 1'b1);
        push_frame(1'b0, 1'b0, 16'h00C3, 1'b1);
        ahb_write(2'd2, 32'h1);
        run_frames(2, 4, 500);
        repeat (8) @(posedge HCLK);
        expect_reg("div3_status_idle", 2'd1, 32'h0000_0002);
    endtask

    task automatic test_overflow();
        ahb_write(2'd3, 32'd0);
        ahb_write(2'd2, 32'h0);
        for (int i = 0; i <= DEPTH; i++)
            push_frame(1'b0, i[0], 16'(8'h10 + i), i < DEPTH);
        expect_reg("full_overflow", 2'd1, 32'h0008_000C);
        ahb_write(2'd1, 32'h8);
        expect_reg("overflow_cleared", 2'd1, 32'h0008_0004);
        ahb_write(2'd2, 32'h1);
        run_frames(DEPTH, 1, 400);
        repeat (4) @(posedge HCLK);
        expect_reg("drained_empty", 2'd1, 32'h0000_0002);
    endtask

    task automatic test_flush();
        ahb_write(2'd2, 32'h0);
        for (int i = 0; i < 3; i++) push_frame(1'b0, 1'b0, 16'h0F0 + 16'(i), 1'b0);
        expect_reg("pre_flush_level", 2'd1, 32'h0003_0000);
        ahb_write(2'd2, 32'h2);
        expect_reg("post_flush_status", 2'd1, 32'h0000_0002);
        expect_reg("flush_reads_zero", 2'd2, 32'h0000_0000);
        ahb_write(2'd2, 32'h1);
    endtask

    task automatic test_irq();
        int falls = 0;
        logic prev = 1'b1, early = 1'b0, seen = 1'b0;
        logic [31:0] rd = 32'h0;
        ahb_write(2'd2, 32'h0000_0204);
        for (int i = 0; i < 4; i++) push_frame(1'b0, 1'b0, 16'h0030 + 16'(i), 1'b0);
        repeat (2) @(posedge HCLK); #1;
        expect_pin("irq_above_thresh", IRQ, 1'b0);
        ahb_write(2'd2, 32'h0000_0205);
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge HCLK); #1;
            if (!nCS && prev) falls++;
            if (falls == 2 && !nCS && prev) begin
                expect_pin("irq_lag_cycle", IRQ, 1'b0);
                @(posedge HCLK); #1;
                expect_pin("irq_rises", IRQ, 1'b1);
                seen = 1'b1;
            end else if (IRQ) begin
                early = 1'b1;
            end
            prev = nCS;
        end
        expect_pin("irq_level2_reached", seen, 1'b1);
        expect_pin("irq_not_early", early, 1'b0);
        for (int i = 0; i < 60 && rd !== 32'h2; i++) ahb_read(2'd1, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL irq_drain: got 0x%08h want 0x00000002", rd);
        end
        expect_pin("irq_empty", IRQ, 1'b1);
        ahb_write(2'd2, 32'h1);
        repeat (2) @(posedge HCLK); #1;
        expect_pin("irq_disabled", IRQ, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int rises = 0, late_rises = 0, late_lows = 0;
        logic prev_sclk = 1'b0;
        ahb_write(2'd3, 32'd3);
        push_frame(1'b1, 1'b1, 16'hBEEF, 1'b0);
        for (int c = 0; c < 400 && rises < 5; c++) begin
            @(posedge HCLK); #1;
            if (SCLK && !prev_sclk) rises++;
            prev_sclk = SCLK;
        end
        expect_pin("mid_frame_reached", rises == 5, 1'b1);
        expect_pin("mid_frame_dnc", DnC, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        expect_pin("abort_ncs", nCS, 1'b1);
        expect_pin("abort_sclk", SCLK, 1'b0);
        expect_pin("abort_sdin", SDIN, 1'b0);
        expect_pin("abort_dnc", DnC, 1'b0);
        expect_pin("abort_irq", IRQ, 1'b0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        prev_sclk = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge HCLK); #1;
            if (SCLK && !prev_sclk) late_rises++;
            if (!nCS) late_lows++;
            prev_sclk = SCLK;
        end
        vectors++;
        if (late_rises !== 0 || late_lows !== 0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got %0d sclk rises %0d ncs-low cycles want 0 0", late_rises, late_lows);
        end
        expect_reg("post_reset_status", 2'd1, 32'h0000_0002);
        expect_reg("post_reset_clkdiv", 2'd3, 32'(DEFAULT_DIV));
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
        HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'b010; HTRANS = 2'b00;
        test_reset();
        test_div0();
        test_div3();
        test_overflow();
        test_flush();
        test_irq();
        test_reset_mid_frame();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d frames want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
